// File: rtl/dev_b_receiver.sv
// B-side receiver: captures sharedBus when an A-device raises ready, acknowledges
// with a registered acceptedB pulse, and buffers bytes in a first-word-fall-through FIFO.
module dev_b_receiver #(
  parameter int DEPTH   = 4,
  parameter int ACK_LEN = 2,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clkB,
  input  logic          rst,
  input  logic [7:0]    sharedBus,
  input  logic          readyA1,
  input  logic          readyA2,
  input  logic          popB,
  output logic          acceptedB,
  output logic [7:0]    dataOutB,
  output logic          validB,
  output logic [CW-1:0] fifoCount,
  output logic          overflowB,
  output logic          collisionB
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW = (ACK_LEN > 1) ? $clog2(ACK_LEN) : 1;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW, STALL} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   ack_cnt_q, ack_cnt_d;
  logic            accepted_q, accepted_d;
  logic            overflow_q, overflow_d;
  logic            collision_q, collision_d;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            rdy, full, push, pop;

  assign rdy  = readyA1 | readyA2;
  assign full = (count_q == CW'(DEPTH));
  assign pop  = popB && (count_q != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkB) begin
    if (rst) begin
      state_q     <= IDLE;
      ack_cnt_q   <= '0;
      accepted_q  <= 1'b0;
      overflow_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_cnt_q   <= ack_cnt_d;
      accepted_q  <= accepted_d;
      overflow_q  <= overflow_d;
      collision_q <= collision_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rdy && !full) begin
          push      = 1'b1;
          ack_cnt_d = '0;
          state_d   = ACK;
        end else if (rdy) begin
          state_d = STALL;
        end
      end
      ACK: begin
        if (ack_cnt_q == KW'(ACK_LEN - 1)) state_d = WAIT_LOW;
        else                               ack_cnt_d = ack_cnt_q + 1'b1;
      end
      WAIT_LOW: begin
        if (!rdy) state_d = IDLE;
      end
      STALL: begin
        // Fullness is judged before any same-cycle pop, so a freed slot is used next cycle.
        if (!rdy) begin
          state_d = IDLE;
        end else if (!full) begin
          push      = 1'b1;
          ack_cnt_d = '0;
          state_d   = ACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accepted_d  = (state_d == ACK);
    overflow_d  = overflow_q | ((state_q == STALL) && !rdy);
    collision_d = collision_q | (readyA1 & readyA2);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clkB) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the head is gated to zero while empty instead.
  always_ff @(posedge clkB) begin
    if (push) mem[wr_ptr_q] <= sharedBus;
  end

  assign acceptedB  = accepted_q;
  assign validB     = (count_q != '0);
  assign dataOutB   = validB ? mem[rd_ptr_q] : 8'h00;
  assign fifoCount  = count_q;
  assign overflowB  = overflow_q;
  assign collisionB = collision_q;

endmodule

// File: tb/tb_dev_b_receiver.sv
// Bench for dev_b_receiver: directed scenarios plus a randomized run against a
// transaction-level queue model of the receiver.
module tb_dev_b_receiver;

  localparam int DEPTH   = 4;
  localparam int ACK_LEN = 2;
  localparam int CW      = 3;

  logic          clkB = 1'b0;
  logic          rst;
  logic [7:0]    sharedBus;
  logic          readyA1, readyA2, popB;
  logic          acceptedB;
  logic [7:0]    dataOutB;
  logic          validB;
  logic [CW-1:0] fifoCount;
  logic          overflowB, collisionB;

  int n_chk  = 0;
  int n_pass = 0;

  dev_b_receiver #(.DEPTH(DEPTH), .ACK_LEN(ACK_LEN), .CW(CW)) dut (
    .clkB       (clkB),
    .rst        (rst),
    .sharedBus  (sharedBus),
    .readyA1    (readyA1),
    .readyA2    (readyA2),
    .popB       (popB),
    .acceptedB  (acceptedB),
    .dataOutB   (dataOutB),
    .validB     (validB),
    .fifoCount  (fifoCount),
    .overflowB  (overflowB),
    .collisionB (collisionB)
  );

  always #5 clkB = ~clkB;

  // One active edge, then land on the falling edge where outputs are sampled and inputs driven.
  task automatic cyc();
    @(posedge clkB);
    @(negedge clkB);
  endtask

  task automatic idle_inputs();
    readyA1   = 1'b0;
    readyA2   = 1'b0;
    popB      = 1'b0;
    sharedBus = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Full handshake from IDLE: capture, drop ready on ack, wait until back in IDLE.
  task automatic xfer(input logic [7:0] d, output logic acc);
    sharedBus = d;
    readyA1   = 1'b1;
    cyc();
    acc     = acceptedB;
    readyA1 = 1'b0;
    repeat (ACK_LEN + 1) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sharedBus = 8'($urandom);
      readyA1   = 1'($urandom);
      readyA2   = 1'($urandom);
      popB      = 1'($urandom);
      cyc();
    end
    n_chk++; if (acceptedB !== 1'b0) $display("FAIL reset_ack: got %b want 0", acceptedB); else n_pass++;
    n_chk++; if (validB !== 1'b0) $display("FAIL reset_valid: got %b want 0", validB); else n_pass++;
    n_chk++; if (fifoCount !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifoCount); else n_pass++;
    n_chk++; if (dataOutB !== 8'h00) $display("FAIL reset_data: got %h want 00", dataOutB); else n_pass++;
    n_chk++; if (overflowB !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflowB); else n_pass++;
    n_chk++; if (collisionB !== 1'b0) $display("FAIL reset_col: got %b want 0", collisionB); else n_pass++;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    sharedBus = 8'hA5;
    readyA1   = 1'b1;
    cyc();
    n_chk++; if (acceptedB !== 1'b1) $display("FAIL single_ack1: got %b want 1", acceptedB); else n_pass++;
    n_chk++; if (validB !== 1'b1) $display("FAIL single_valid: got %b want 1", validB); else n_pass++;
    n_chk++; if (dataOutB !== 8'hA5) $display("FAIL single_data: got %h want a5", dataOutB); else n_pass++;
    n_chk++; if (fifoCount !== 3'd1) $display("FAIL single_count: got %0d want 1", fifoCount); else n_pass++;
    readyA1 = 1'b0;
    cyc();
    n_chk++; if (acceptedB !== 1'b1) $display("FAIL single_ack2: got %b want 1", acceptedB); else n_pass++;
    cyc();
    n_chk++; if (acceptedB !== 1'b0) $display("FAIL single_ack_end: got %b want 0", acceptedB); else n_pass++;
    repeat (2) cyc();
    n_chk++; if (fifoCount !== 3'd1) $display("FAIL single_no_dup: got %0d want 1", fifoCount); else n_pass++;
    popB = 1'b1;
    cyc();
    popB = 1'b0;
    n_chk++; if (fifoCount !== 3'd0) $display("FAIL single_pop_count: got %0d want 0", fifoCount); else n_pass++;
    n_chk++; if (validB !== 1'b0) $display("FAIL single_pop_valid: got %b want 0", validB); else n_pass++;
    popB = 1'b1;
    cyc();
    popB = 1'b0;
    n_chk++; if (fifoCount !== 3'd0) $display("FAIL single_underflow: got %0d want 0", fifoCount); else n_pass++;
  endtask

  task automatic test_fill_stall();
    logic acc;
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      xfer(8'(i), acc);
      n_chk++; if (acc !== 1'b1) $display("FAIL fill_ack%0d: got %b want 1", i, acc); else n_pass++;
    end
    n_chk++; if (fifoCount !== 3'd4) $display("FAIL fill_count: got %0d want 4", fifoCount); else n_pass++;
    sharedBus = 8'h05;
    readyA1   = 1'b1;
    repeat (2) cyc();
    n_chk++; if (acceptedB !== 1'b0) $display("FAIL stall_ack: got %b want 0", acceptedB); else n_pass++;
    popB = 1'b1;
    cyc();
    popB = 1'b0;
    n_chk++; if (acceptedB !== 1'b0) $display("FAIL stall_pop_ack: got %b want 0", acceptedB); else n_pass++;
    n_chk++; if (fifoCount !== 3'd3) $display("FAIL stall_pop_count: got %0d want 3", fifoCount); else n_pass++;
    cyc();
    n_chk++; if (acceptedB !== 1'b1) $display("FAIL stall_capture_ack: got %b want 1", acceptedB); else n_pass++;
    n_chk++; if (fifoCount !== 3'd4) $display("FAIL stall_capture_count: got %0d want 4", fifoCount); else n_pass++;
    readyA1 = 1'b0;
    repeat (ACK_LEN + 1) cyc();
    for (int i = 2; i <= 5; i++) begin
      n_chk++; if (dataOutB !== 8'(i)) $display("FAIL stall_order%0d: got %h want %h", i, dataOutB, 8'(i)); else n_pass++;
      popB = 1'b1;
      cyc();
      popB = 1'b0;
    end
    n_chk++; if (validB !== 1'b0) $display("FAIL stall_drain: got %b want 0", validB); else n_pass++;
    n_chk++; if (overflowB !== 1'b0) $display("FAIL stall_no_ovf: got %b want 0", overflowB); else n_pass++;
  endtask

  task automatic test_overflow();
    logic acc;
    do_reset();
    for (int i = 0; i < DEPTH; i++) xfer(8'h10 + 8'(i), acc);
    sharedBus = 8'h77;
    readyA2   = 1'b1;
    repeat (2) cyc();
    n_chk++; if (acceptedB !== 1'b0) $display("FAIL ovf_ack: got %b want 0", acceptedB); else n_pass++;
    n_chk++; if (overflowB !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflowB); else n_pass++;
    readyA2 = 1'b0;
    cyc();
    n_chk++; if (overflowB !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflowB); else n_pass++;
    n_chk++; if (fifoCount !== 3'd4) $display("FAIL ovf_count: got %0d want 4", fifoCount); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_chk++; if (dataOutB !== 8'h10 + 8'(i)) $display("FAIL ovf_data%0d: got %h want %h", i, dataOutB, 8'h10 + 8'(i)); else n_pass++;
      popB = 1'b1;
      cyc();
      popB = 1'b0;
    end
    n_chk++; if (validB !== 1'b0) $display("FAIL ovf_empty: got %b want 0", validB); else n_pass++;
    n_chk++; if (overflowB !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflowB); else n_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    sharedBus = 8'h3C;
    readyA1   = 1'b1;
    readyA2   = 1'b1;
    cyc();
    n_chk++; if (collisionB !== 1'b1) $display("FAIL col_set: got %b want 1", collisionB); else n_pass++;
    n_chk++; if (dataOutB !== 8'h3C) $display("FAIL col_data: got %h want 3c", dataOutB); else n_pass++;
    readyA1 = 1'b0;
    readyA2 = 1'b0;
    repeat (ACK_LEN + 2) cyc();
    n_chk++; if (fifoCount !== 3'd1) $display("FAIL col_count: got %0d want 1", fifoCount); else n_pass++;
    n_chk++; if (collisionB !== 1'b1) $display("FAIL col_sticky: got %b want 1", collisionB); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic acc;
    do_reset();
    xfer(8'h11, acc);
    sharedBus = 8'h22;
    readyA1   = 1'b1;
    cyc();
    readyA1 = 1'b0;
    cyc();
    n_chk++; if (acceptedB !== 1'b1 || fifoCount !== 3'd2)
      $display("FAIL mid_pre: got ack=%b cnt=%0d want ack=1 cnt=2", acceptedB, fifoCount); else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_chk++; if (acceptedB !== 1'b0) $display("FAIL mid_ack: got %b want 0", acceptedB); else n_pass++;
    n_chk++; if (fifoCount !== 3'd0) $display("FAIL mid_count: got %0d want 0", fifoCount); else n_pass++;
    n_chk++; if (validB !== 1'b0) $display("FAIL mid_valid: got %b want 0", validB); else n_pass++;
    xfer(8'h33, acc);
    n_chk++; if (acc !== 1'b1) $display("FAIL mid_idle_ack: got %b want 1", acc); else n_pass++;
    n_chk++; if (dataOutB !== 8'h33) $display("FAIL mid_idle_data: got %h want 33", dataOutB); else n_pass++;
  endtask

  // Randomized: a well-behaved sender (holds ready until acknowledged, sometimes gives up
  // while blocked) and a random popper, checked every cycle against a queue model.
  task automatic test_random();
    logic [7:0] mq[$];
    logic [7:0] data_v, exp_data;
    int         ack_left, gap, sel, sz;
    bit         pending, stalled, ovf, col, push;
    do_reset();
    ack_left = 0; gap = 0; sel = 2; data_v = 8'h00;
    pending = 0; stalled = 0; ovf = 0; col = 0;
    for (int c = 0; c < 800; c++) begin
      if (pending && stalled && $urandom_range(0, 5) == 0) begin
        pending = 0;
      end else if (!pending && ack_left == 0 && gap == 0 && $urandom_range(0, 2) == 0) begin
        pending = 1;
        data_v  = 8'($urandom);
        sel     = int'($urandom_range(0, 7));
      end
      readyA1   = pending && (sel != 1);
      readyA2   = pending && (sel <= 1);
      sharedBus = pending ? data_v : 8'($urandom);
      popB      = ($urandom_range(0, 3) == 0);
      @(posedge clkB);
      sz = mq.size();
      if (readyA1 && readyA2) col = 1;
      push = pending && (sz < DEPTH);
      if (popB && sz > 0) void'(mq.pop_front());
      if (push) begin
        mq.push_back(data_v);
        pending  = 0;
        stalled  = 0;
        ack_left = ACK_LEN;
        gap      = 1;
      end else begin
        if (pending) stalled = 1;
        else if (stalled) begin
          ovf     = 1;
          stalled = 0;
        end
        if (ack_left > 0) ack_left--;
        else if (gap > 0) gap--;
      end
      @(negedge clkB);
      exp_data = (mq.size() > 0) ? mq[0] : 8'h00;
      n_chk++; if (acceptedB !== (ack_left > 0)) $display("FAIL rnd_ack c%0d: got %b want %b", c, acceptedB, ack_left > 0); else n_pass++;
      n_chk++; if (fifoCount !== CW'(mq.size())) $display("FAIL rnd_count c%0d: got %0d want %0d", c, fifoCount, mq.size()); else n_pass++;
      n_chk++; if (validB !== (mq.size() > 0)) $display("FAIL rnd_valid c%0d: got %b want %b", c, validB, mq.size() > 0); else n_pass++;
      n_chk++; if (dataOutB !== exp_data) $display("FAIL rnd_data c%0d: got %h want %h", c, dataOutB, exp_data); else n_pass++;
      n_chk++; if (overflowB !== ovf) $display("FAIL rnd_ovf c%0d: got %b want %b", c, overflowB, ovf); else n_pass++;
      n_chk++; if (collisionB !== col) $display("FAIL rnd_col c%0d: got %b want %b", c, collisionB, col); else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_fill_stall();
    test_overflow();
    test_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
